// File: rtl/sram_rw_port_arbiter.sv
// Round-robin sharing of the OpenRAM 1rw1r port 0 between two requesters,
// with a two-stage response pipeline and a port-0/port-1 collision monitor.
module sram_rw_port_arbiter #(
    parameter int AW       = 10,
    parameter int MACRO_AW = 12,
    parameter int DW       = 32,
    parameter int NBE      = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*AW-1:0]     addr_i,
    input  logic [2*DW-1:0]     wdata_i,
    input  logic [2*NBE-1:0]    be_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rvalid_o,
    output logic [DW-1:0]       rdata_o,
    output logic                csb0_o,
    output logic                web0_o,
    output logic [NBE-1:0]      wmask0_o,
    output logic [MACRO_AW-1:0] addr0_o,
    output logic [DW-1:0]       din0_o,
    input  logic [DW-1:0]       dout0_i,
    input  logic                csb1_i,
    input  logic [MACRO_AW-1:0] addr1_i,
    output logic                collision_o
);

    logic                granted;
    logic                win_id;
    logic                ptr;
    logic                win_we;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic [NBE-1:0]      win_be;
    logic                write_nop;
    logic [MACRO_AW-1:0] hold_addr;
    logic [DW-1:0]       hold_din;
    logic [NBE-1:0]      hold_mask;
    logic                s1_valid;
    logic                s1_id;
    logic                s1_read;
    logic                s2_valid;
    logic                s2_id;
    logic [DW-1:0]       rdata_q;
    logic                collision_q;

    // Grants are suppressed while reset is held so the macro goes idle at once.
    always_comb begin
        granted = 1'b0;
        win_id  = 1'b0;
        if (!rst_i) begin
            unique case (req_i)
                2'b01:   begin granted = 1'b1; win_id = 1'b0; end
                2'b10:   begin granted = 1'b1; win_id = 1'b1; end
                2'b11:   begin granted = 1'b1; win_id = ptr;  end
                default: begin granted = 1'b0; win_id = 1'b0; end
            endcase
        end
    end

    assign gnt_o     = granted ? (2'b01 << win_id) : 2'b00;
    assign win_we    = win_id ? we_i[1] : we_i[0];
    assign win_addr  = win_id ? addr_i[AW +: AW]   : addr_i[0 +: AW];
    assign win_wdata = win_id ? wdata_i[DW +: DW]  : wdata_i[0 +: DW];
    assign win_be    = win_id ? be_i[NBE +: NBE]   : be_i[0 +: NBE];
    assign write_nop = win_we && (win_be == '0);

    assign csb0_o   = !(granted && !write_nop);
    assign web0_o   = granted ? !win_we : 1'b1;
    assign addr0_o  = granted ? {{(MACRO_AW-AW){1'b0}}, win_addr} : hold_addr;
    assign din0_o   = granted ? win_wdata : hold_din;
    assign wmask0_o = granted ? win_be : hold_mask;

    // Last driven macro inputs are kept so idle cycles do not toggle the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= 1'b0;
            hold_addr <= '0;
            hold_din  <= '0;
            hold_mask <= '0;
        end else if (granted) begin
            ptr       <= ~win_id;
            hold_addr <= {{(MACRO_AW-AW){1'b0}}, win_addr};
            hold_din  <= win_wdata;
            hold_mask <= win_be;
        end
    end

    // dout0 is only valid around the end of N+1, so stage2 captures it there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_id       <= 1'b0;
            s1_read     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_id       <= 1'b0;
            rdata_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            s1_valid    <= granted;
            s1_id       <= win_id;
            s1_read     <= !win_we;
            s2_valid    <= s1_valid;
            s2_id       <= s1_id;
            if (s1_valid) begin
                rdata_q <= s1_read ? dout0_i : '0;
            end
            collision_q <= !csb0_o && !web0_o && !csb1_i && (addr1_i == addr0_o);
        end
    end

    assign rvalid_o    = s2_valid ? (2'b01 << s2_id) : 2'b00;
    assign rdata_o     = rdata_q;
    assign collision_o = collision_q;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Bench for sram_rw_port_arbiter: SRAM macro model, reference model with a
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_sram_rw_port_arbiter;

    localparam int AW       = 10;
    localparam int MACRO_AW = 12;
    localparam int DW       = 32;
    localparam int NBE      = 4;

    logic                clk_i   = 1'b0;
    logic                rst_i   = 1'b1;
    logic [1:0]          req_i   = '0;
    logic [1:0]          we_i    = '0;
    logic [2*AW-1:0]     addr_i  = '0;
    logic [2*DW-1:0]     wdata_i = '0;
    logic [2*NBE-1:0]    be_i    = '0;
    logic [DW-1:0]       dout0_i = '0;
    logic                csb1_i  = 1'b1;
    logic [MACRO_AW-1:0] addr1_i = '0;
    logic [1:0]          gnt_o;
    logic [1:0]          rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic                csb0_o;
    logic                web0_o;
    logic [NBE-1:0]      wmask0_o;
    logic [MACRO_AW-1:0] addr0_o;
    logic [DW-1:0]       din0_o;
    logic                collision_o;

    int checks = 0;
    int errors = 0;

    sram_rw_port_arbiter #(.AW(AW), .MACRO_AW(MACRO_AW), .DW(DW), .NBE(NBE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o),
        .addr0_o(addr0_o), .din0_o(din0_o), .dout0_i(dout0_i), .csb1_i(csb1_i),
        .addr1_i(addr1_i), .collision_o(collision_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic apply_stimulus(input int r, input logic req, input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [NBE-1:0] be);
        req_i[r]             = req;
        we_i[r]              = we;
        addr_i[r*AW +: AW]   = addr;
        wdata_i[r*DW +: DW]  = wdata;
        be_i[r*NBE +: NBE]   = be;
    endtask

    // Macro port 0: writes land at the negedge of the issue cycle, read data
    // appears at the next negedge and turns to garbage just after the edge after that.
    logic [DW-1:0] mac_mem [1024];
    logic          mac_rd_pend = 1'b0;
    logic [DW-1:0] mac_rd_data = '0;

    initial begin
        for (int i = 0; i < 1024; i++) mac_mem[i] = '0;
        forever begin
            @(negedge clk_i);
            if (mac_rd_pend) dout0_i = mac_rd_data;
            mac_rd_pend = !csb0_o && web0_o;
            if (mac_rd_pend) mac_rd_data = mac_mem[addr0_o[AW-1:0]];
            if (!csb0_o && !web0_o) begin
                for (int b = 0; b < NBE; b++)
                    if (wmask0_o[b]) mac_mem[addr0_o[AW-1:0]][b*8 +: 8] = din0_o[b*8 +: 8];
            end
            @(posedge clk_i);
            #1 dout0_i = $urandom();
        end
    end

    // Reference model: requests seen mid-cycle, responses delayed by two cycles.
    typedef struct packed {
        logic          valid;
        logic          id;
        logic [DW-1:0] data;
    } resp_t;

    resp_t               pipe_q[$];
    logic [DW-1:0]       ref_mem [1024];
    int                  m_ptr = 0;
    logic [DW-1:0]       m_rdata = '0;
    logic                m_coll = 1'b0;
    logic                hold_known = 1'b0;
    logic [MACRO_AW-1:0] m_addr0 = '0;
    logic [DW-1:0]       m_din = '0;
    logic [NBE-1:0]      m_mask = '0;

    initial for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    always @(negedge clk_i) begin : model_compare
        int             win;
        logic [1:0]     exp_gnt;
        logic [1:0]     exp_rv;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [NBE-1:0] be;
        logic           next_coll;
        resp_t          cur;
        resp_t          due;
        if (rst_i) begin
            check_output("rst_gnt", 64'(gnt_o), 64'(0));
            check_output("rst_rvalid", 64'(rvalid_o), 64'(0));
            check_output("rst_rdata", 64'(rdata_o), 64'(0));
            check_output("rst_collision", 64'(collision_o), 64'(0));
            check_output("rst_csb0", 64'(csb0_o), 64'(1));
            check_output("rst_web0", 64'(web0_o), 64'(1));
            pipe_q.delete();
            m_ptr      = 0;
            m_rdata    = '0;
            m_coll     = 1'b0;
            hold_known = 1'b0;
        end else begin
            win = -1;
            if (req_i == 2'b11) win = m_ptr;
            else if (req_i[0]) win = 0;
            else if (req_i[1]) win = 1;
            exp_gnt = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
            check_output("gnt", 64'(gnt_o), 64'(exp_gnt));
            cur       = '0;
            next_coll = 1'b0;
            if (win >= 0) begin
                we    = we_i[win];
                addr  = addr_i[win*AW +: AW];
                wdata = wdata_i[win*DW +: DW];
                be    = be_i[win*NBE +: NBE];
                check_output("csb0", 64'(csb0_o), 64'(we && be == '0));
                check_output("web0", 64'(web0_o), 64'(!we));
                check_output("addr0", 64'(addr0_o), 64'(addr));
                check_output("din0", 64'(din0_o), 64'(wdata));
                check_output("wmask0", 64'(wmask0_o), 64'(be));
                hold_known = 1'b1;
                m_addr0    = MACRO_AW'(addr);
                m_din      = wdata;
                m_mask     = be;
                cur.valid  = 1'b1;
                cur.id     = (win == 1);
                if (we) begin
                    for (int b = 0; b < NBE; b++)
                        if (be[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
                    cur.data = '0;
                end else begin
                    cur.data = ref_mem[addr];
                end
                next_coll = we && (be != '0) && !csb1_i && (addr1_i == MACRO_AW'(addr));
                m_ptr = 1 - win;
            end else begin
                check_output("idle_csb0", 64'(csb0_o), 64'(1));
                check_output("idle_web0", 64'(web0_o), 64'(1));
                if (hold_known) begin
                    check_output("hold_addr0", 64'(addr0_o), 64'(m_addr0));
                    check_output("hold_din0", 64'(din0_o), 64'(m_din));
                    check_output("hold_wmask0", 64'(wmask0_o), 64'(m_mask));
                end
            end
            check_output("collision", 64'(collision_o), 64'(m_coll));
            m_coll = next_coll;
            due = '0;
            if (pipe_q.size() == 2) due = pipe_q.pop_front();
            pipe_q.push_back(cur);
            if (due.valid) m_rdata = due.data;
            exp_rv = due.valid ? (due.id ? 2'b10 : 2'b01) : 2'b00;
            check_output("rvalid", 64'(rvalid_o), 64'(exp_rv));
            check_output("rdata", 64'(rdata_o), 64'(m_rdata));
        end
    end

    initial begin
        tick();
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_output("lit_idle_csb0", 64'(csb0_o), 64'(1));
            check_output("lit_idle_gnt", 64'(gnt_o), 64'(0));
            check_output("lit_idle_rvalid", 64'(rvalid_o), 64'(0));
            tick();
        end

        // Full write then read of address 5 by requester 0
        apply_stimulus(0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clk_i); check_output("lit_wr_gnt", 64'(gnt_o), 64'(2'b01)); tick();
        apply_stimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
        @(negedge clk_i); check_output("lit_rd_gnt", 64'(gnt_o), 64'(2'b01)); tick();
        apply_stimulus(0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        @(negedge clk_i);
        check_output("lit_wr_rvalid", 64'(rvalid_o), 64'(2'b01));
        check_output("lit_wr_rdata", 64'(rdata_o), 64'(0));
        tick();
        @(negedge clk_i);
        check_output("lit_rd_rvalid", 64'(rvalid_o), 64'(2'b01));
        check_output("lit_rd_rdata", 64'(rdata_o), 64'(32'hDEADBEEF));
        tick();

        // Byte 1 only: DE AD BE EF becomes DE AD AA EF
        apply_stimulus(0, 1'b1, 1'b1, 10'd5, 32'h0000AA00, 4'b0010);
        tick();
        apply_stimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
        tick();
        apply_stimulus(0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        tick();
        @(negedge clk_i);
        check_output("lit_partial_rvalid", 64'(rvalid_o), 64'(2'b01));
        check_output("lit_partial_rdata", 64'(rdata_o), 64'(32'hDEADAAEF));
        tick();

        // R1 write leaves the priority pointer on R0 before the contention run
        apply_stimulus(1, 1'b1, 1'b1, 10'd9, 32'h12345678, 4'hF);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        tick(); tick();

        apply_stimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
        apply_stimulus(1, 1'b1, 1'b0, 10'd9, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 6) req_i = 2'b00;
            @(negedge clk_i);
            if (i < 6) check_output("lit_rr_gnt", 64'(gnt_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            if (i >= 2) begin
                check_output("lit_rr_rvalid", 64'(rvalid_o), 64'(((i - 2) % 2 == 0) ? 2'b01 : 2'b10));
                check_output("lit_rr_rdata", 64'(rdata_o),
                             64'(((i - 2) % 2 == 0) ? 32'hDEADAAEF : 32'h12345678));
            end
            tick();
        end

        // Same-address write/read collision, then a different address
        apply_stimulus(0, 1'b1, 1'b1, 10'd7, 32'hCAFEF00D, 4'hF);
        csb1_i = 1'b0; addr1_i = 12'd7;
        tick();
        apply_stimulus(0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        csb1_i = 1'b1;
        @(negedge clk_i); check_output("lit_coll_hit", 64'(collision_o), 64'(1)); tick();
        @(negedge clk_i); check_output("lit_coll_pulse", 64'(collision_o), 64'(0)); tick();
        apply_stimulus(0, 1'b1, 1'b1, 10'd8, 32'h0BADF00D, 4'hF);
        csb1_i = 1'b0; addr1_i = 12'd7;
        tick();
        apply_stimulus(0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        csb1_i = 1'b1;
        @(negedge clk_i); check_output("lit_coll_miss", 64'(collision_o), 64'(0)); tick();
        tick();

        // Reset with two reads in flight; pointer left on R1 beforehand
        apply_stimulus(1, 1'b1, 1'b0, 10'd9, 32'h0, 4'h0);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        apply_stimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
        tick();
        rst_i = 1'b1;
        req_i = 2'b00;
        @(negedge clk_i); check_output("lit_rst_rvalid", 64'(rvalid_o), 64'(0)); tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); check_output("lit_post_rst_rvalid", 64'(rvalid_o), 64'(0)); tick();
        end
        req_i = 2'b11;
        @(negedge clk_i); check_output("lit_post_rst_gnt", 64'(gnt_o), 64'(2'b01)); tick();
        req_i = 2'b00;
        tick(); tick(); tick();

        // Randomized traffic over a small address window, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                apply_stimulus(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                               AW'($urandom_range(0, 15)), $urandom(),
                               ($urandom_range(0, 7) == 0) ? 4'h0 : NBE'($urandom()));
            end
            csb1_i  = 1'($urandom_range(0, 1));
            addr1_i = ($urandom_range(0, 3) == 0) ? MACRO_AW'($urandom()) : MACRO_AW'($urandom_range(0, 15));
            rst_i   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i  = 1'b0;
        req_i  = 2'b00;
        csb1_i = 1'b1;
        tick(); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
